// File: rtl/axi_sram.sv
// AXI-style burst SRAM slave: single-ported word array with byte-strobed writes,
// 2-cycle read latency, out-of-range error reporting and a side-band loader port.
module axi_sram #(
    parameter int unsigned MEM_SIZE   = 'h40000,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic [31:0]                axi_awaddr,
    input  logic [7:0]                 axi_awlen,
    input  logic                       axi_awvalid,
    output logic                       axi_awready,

    input  logic [DATA_WIDTH-1:0]      axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]    axi_wstrb,
    input  logic                       axi_wlast,
    input  logic                       axi_wvalid,
    output logic                       axi_wready,

    output logic [1:0]                 axi_bresp,
    output logic                       axi_bvalid,
    input  logic                       axi_bready,

    input  logic [31:0]                axi_araddr,
    input  logic [7:0]                 axi_arlen,
    input  logic                       axi_arvalid,
    output logic                       axi_arready,

    output logic [DATA_WIDTH-1:0]      axi_rdata,
    output logic [1:0]                 axi_rresp,
    output logic                       axi_rlast,
    output logic                       axi_rvalid,
    input  logic                       axi_rready,

    input  logic                       loader_we,
    input  logic [31:0]                loader_addr,
    input  logic [DATA_WIDTH-1:0]      loader_data
);

    localparam int unsigned BYTE_LANES = DATA_WIDTH / 8;
    localparam int unsigned WORD_SHIFT = $clog2(BYTE_LANES);
    localparam int unsigned IDX_W      = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

    typedef enum logic [2:0] {
        IDLE,
        READ_ADDR,
        READ_BURST,
        WRITE_BURST,
        WRITE_RESP
    } state_t;

    logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

    state_t                state_q, state_d;
    logic [31:0]           addr_q, addr_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;

    logic                  addr_ok;
    logic [IDX_W-1:0]      mem_idx;
    logic [31:0]           loader_word;
    logic                  loader_ok;
    logic                  w_beat;
    logic                  r_beat;

    // Address decode for the burst pointer and the loader port
    assign addr_ok     = addr_q < 32'(MEM_SIZE);
    assign mem_idx     = addr_q[IDX_W-1:0];
    assign loader_word = loader_addr >> WORD_SHIFT;
    assign loader_ok   = loader_word < 32'(MEM_SIZE);

    // Handshake outputs decoded from state; reset forces them low immediately
    assign axi_awready = !reset && (state_q == IDLE);
    assign axi_arready = !reset && (state_q == IDLE);
    assign axi_wready  = !reset && (state_q == WRITE_BURST) && !loader_we;
    assign axi_bvalid  = !reset && (state_q == WRITE_RESP);
    assign axi_bresp   = (!reset && err_q) ? 2'b10 : 2'b00;
    assign axi_rvalid  = !reset && (state_q == READ_BURST);
    assign axi_rlast   = axi_rvalid && (cnt_q == 8'd0);
    assign axi_rresp   = axi_rvalid ? rresp_q : 2'b00;
    assign axi_rdata   = rdata_q;

    assign w_beat = axi_wvalid && axi_wready;
    assign r_beat = axi_rvalid && axi_rready;

    // Next-state and burst bookkeeping
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        rresp_d = rresp_q;
        case (state_q)
            IDLE: begin
                if (axi_awvalid) begin
                    addr_d  = axi_awaddr >> WORD_SHIFT;
                    cnt_d   = axi_awlen;
                    err_d   = 1'b0;
                    state_d = WRITE_BURST;
                end else if (axi_arvalid) begin
                    addr_d  = axi_araddr >> WORD_SHIFT;
                    cnt_d   = axi_arlen;
                    err_d   = 1'b0;
                    state_d = READ_ADDR;
                end
            end
            READ_ADDR: begin
                if (addr_ok) begin
                    rdata_d = mem[mem_idx];
                    rresp_d = 2'b00;
                end else begin
                    rdata_d = '0;
                    rresp_d = 2'b10;
                    err_d   = 1'b1;
                end
                state_d = READ_BURST;
            end
            READ_BURST: begin
                if (r_beat) begin
                    if (cnt_q == 8'd0) begin
                        state_d = IDLE;
                    end else begin
                        addr_d  = addr_q + 32'd1;
                        cnt_d   = cnt_q - 8'd1;
                        state_d = READ_ADDR;
                    end
                end
            end
            WRITE_BURST: begin
                if (w_beat) begin
                    if (!addr_ok || (axi_wlast != (cnt_q == 8'd0))) begin
                        err_d = 1'b1;
                    end
                    if (cnt_q == 8'd0) begin
                        state_d = WRITE_RESP;
                    end else begin
                        addr_d = addr_q + 32'd1;
                        cnt_d  = cnt_q - 8'd1;
                    end
                end
            end
            WRITE_RESP: begin
                if (axi_bready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and burst registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            rresp_q <= 2'b00;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            rresp_q <= rresp_d;
        end
    end

    // Single SRAM write port: loader wins (and ignores reset), else strobed AXI beat
    always_ff @(posedge clk) begin
        if (loader_we) begin
            if (loader_ok) begin
                mem[loader_word[IDX_W-1:0]] <= loader_data;
            end
        end else if (w_beat && addr_ok) begin
            for (int b = 0; b < int'(BYTE_LANES); b++) begin
                if (axi_wstrb[b]) begin
                    mem[mem_idx][b*8 +: 8] <= axi_wdata[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_sram.sv
// Directed self-checking bench for axi_sram (MEM_SIZE=16, DATA_WIDTH=32).
module tb_axi_sram;

    localparam int unsigned DW = 32;
    localparam int unsigned MS = 16;

    logic          clk;
    logic          reset;
    logic [31:0]   axi_awaddr;
    logic [7:0]    axi_awlen;
    logic          axi_awvalid;
    logic          axi_awready;
    logic [DW-1:0] axi_wdata;
    logic [3:0]    axi_wstrb;
    logic          axi_wlast;
    logic          axi_wvalid;
    logic          axi_wready;
    logic [1:0]    axi_bresp;
    logic          axi_bvalid;
    logic          axi_bready;
    logic [31:0]   axi_araddr;
    logic [7:0]    axi_arlen;
    logic          axi_arvalid;
    logic          axi_arready;
    logic [DW-1:0] axi_rdata;
    logic [1:0]    axi_rresp;
    logic          axi_rlast;
    logic          axi_rvalid;
    logic          axi_rready;
    logic          loader_we;
    logic [31:0]   loader_addr;
    logic [DW-1:0] loader_data;

    int tests;
    int fails;

    logic [31:0] wr_data [8];
    logic [31:0] rd_data [8];
    logic [1:0]  rd_resp [8];
    logic        rd_last [8];

    axi_sram #(.MEM_SIZE(MS), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .loader_we(loader_we), .loader_addr(loader_addr), .loader_data(loader_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Drives one write burst from posedge+1; returns bresp and a timeout flag.
    task automatic write_burst(input logic [31:0] addr, input int n, input logic [3:0] strb,
                               input bit bad_last, output logic [1:0] bresp, output bit to);
        int c;
        to = 1'b0;
        axi_awaddr = addr; axi_awlen = 8'(n - 1); axi_awvalid = 1'b1; #1;
        c = 0;
        while (!axi_awready && c < 50) begin @(posedge clk); #2; c++; end
        if (c >= 50) to = 1'b1;
        @(posedge clk); #1; axi_awvalid = 1'b0;
        for (int i = 0; i < n; i++) begin
            axi_wdata = wr_data[i]; axi_wstrb = strb;
            axi_wlast = !bad_last && (i == n - 1); axi_wvalid = 1'b1; #1;
            c = 0;
            while (!axi_wready && c < 50) begin @(posedge clk); #2; c++; end
            if (c >= 50) to = 1'b1;
            @(posedge clk); #1;
        end
        axi_wvalid = 1'b0; axi_wlast = 1'b0; axi_bready = 1'b1; #1;
        c = 0;
        while (!axi_bvalid && c < 50) begin @(posedge clk); #2; c++; end
        if (c >= 50) to = 1'b1;
        bresp = axi_bresp;
        @(posedge clk); #1; axi_bready = 1'b0;
    endtask

    // Drives one read burst with rready held high; fills rd_* and first-beat latency in edges.
    task automatic read_burst(input logic [31:0] addr, input int n, output int lat, output bit to);
        int c;
        to = 1'b0; lat = 0;
        axi_araddr = addr; axi_arlen = 8'(n - 1); axi_arvalid = 1'b1; #1;
        c = 0;
        while (!axi_arready && c < 50) begin @(posedge clk); #2; c++; end
        if (c >= 50) to = 1'b1;
        @(posedge clk); #1; axi_arvalid = 1'b0; axi_rready = 1'b1;
        for (int i = 0; i < n; i++) begin
            #1;
            c = 0;
            while (!axi_rvalid && c < 50) begin @(posedge clk); #2; c++; end
            if (c >= 50) to = 1'b1;
            if (i == 0) lat = c + 1;
            rd_data[i] = axi_rdata; rd_resp[i] = axi_rresp; rd_last[i] = axi_rlast;
            @(posedge clk); #1;
        end
        axi_rready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; axi_awvalid = 1'b1; axi_arvalid = 1'b1;
        tick(); tick(); #1;
        tests++; if (axi_awready !== 1'b0) begin fails++; $display("FAIL reset_awready got %b want 0", axi_awready); end
        tests++; if (axi_arready !== 1'b0) begin fails++; $display("FAIL reset_arready got %b want 0", axi_arready); end
        tests++; if (axi_wready !== 1'b0) begin fails++; $display("FAIL reset_wready got %b want 0", axi_wready); end
        tests++; if (axi_rvalid !== 1'b0) begin fails++; $display("FAIL reset_rvalid got %b want 0", axi_rvalid); end
        tests++; if (axi_bvalid !== 1'b0) begin fails++; $display("FAIL reset_bvalid got %b want 0", axi_bvalid); end
        tests++; if (axi_rresp !== 2'b00) begin fails++; $display("FAIL reset_rresp got %b want 00", axi_rresp); end
        tests++; if (axi_bresp !== 2'b00) begin fails++; $display("FAIL reset_bresp got %b want 00", axi_bresp); end
        tests++; if (axi_rlast !== 1'b0) begin fails++; $display("FAIL reset_rlast got %b want 0", axi_rlast); end
        tick();
        axi_awvalid = 1'b0; axi_arvalid = 1'b0; reset = 1'b0; #1;
        tests++; if (axi_awready !== 1'b1) begin fails++; $display("FAIL idle_awready got %b want 1", axi_awready); end
        tests++; if (axi_arready !== 1'b1) begin fails++; $display("FAIL idle_arready got %b want 1", axi_arready); end
        tick();
    endtask

    task automatic test_burst();
        logic [1:0] br; bit to; int lat;
        for (int i = 0; i < 4; i++) wr_data[i] = 32'hA0 + 32'(i);
        write_burst(32'h10, 4, 4'hF, 1'b0, br, to);
        tests++; if (to) begin fails++; $display("FAIL burst_wr_timeout got timeout want none"); end
        tests++; if (br !== 2'b00) begin fails++; $display("FAIL burst_bresp got %b want 00", br); end
        read_burst(32'h10, 4, lat, to);
        tests++; if (to) begin fails++; $display("FAIL burst_rd_timeout got timeout want none"); end
        tests++; if (lat != 2) begin fails++; $display("FAIL burst_latency got %0d want 2", lat); end
        for (int i = 0; i < 4; i++) begin
            tests++; if (rd_data[i] !== 32'hA0 + 32'(i)) begin fails++; $display("FAIL burst_rdata[%0d] got %h want %h", i, rd_data[i], 32'hA0 + 32'(i)); end
            tests++; if (rd_last[i] !== (i == 3)) begin fails++; $display("FAIL burst_rlast[%0d] got %b want %b", i, rd_last[i], (i == 3)); end
            tests++; if (rd_resp[i] !== 2'b00) begin fails++; $display("FAIL burst_rresp[%0d] got %b want 00", i, rd_resp[i]); end
        end
    endtask

    task automatic test_strobe();
        logic [1:0] br; bit to; int lat;
        wr_data[0] = 32'hFFFF_FFFF;
        write_burst(32'h0, 1, 4'hF, 1'b0, br, to);
        wr_data[0] = 32'h1122_3344;
        write_burst(32'h0, 1, 4'b0101, 1'b0, br, to);
        read_burst(32'h0, 1, lat, to);
        tests++; if (rd_data[0] !== 32'hFF22_FF44) begin fails++; $display("FAIL strobe_mix got %h want ff22ff44", rd_data[0]); end
        wr_data[0] = 32'h0000_0000;
        write_burst(32'h0, 1, 4'b0000, 1'b0, br, to);
        read_burst(32'h0, 1, lat, to);
        tests++; if (rd_data[0] !== 32'hFF22_FF44) begin fails++; $display("FAIL strobe_zero got %h want ff22ff44", rd_data[0]); end
        tests++; if (to) begin fails++; $display("FAIL strobe_timeout got timeout want none"); end
    endtask

    task automatic test_oob();
        logic [1:0] br; bit to; int lat;
        wr_data[0] = 32'hE0E0_E0E0; wr_data[1] = 32'hF0F0_F0F0;
        write_burst(32'h38, 2, 4'hF, 1'b0, br, to);
        tests++; if (br !== 2'b00) begin fails++; $display("FAIL oob_prep_bresp got %b want 00", br); end
        read_burst(32'h38, 4, lat, to);
        tests++; if (rd_data[0] !== 32'hE0E0_E0E0 || rd_resp[0] !== 2'b00) begin fails++; $display("FAIL oob_beat0 got %h/%b want e0e0e0e0/00", rd_data[0], rd_resp[0]); end
        tests++; if (rd_data[1] !== 32'hF0F0_F0F0 || rd_resp[1] !== 2'b00) begin fails++; $display("FAIL oob_beat1 got %h/%b want f0f0f0f0/00", rd_data[1], rd_resp[1]); end
        tests++; if (rd_data[2] !== 32'h0 || rd_resp[2] !== 2'b10) begin fails++; $display("FAIL oob_beat2 got %h/%b want 00000000/10", rd_data[2], rd_resp[2]); end
        tests++; if (rd_data[3] !== 32'h0 || rd_resp[3] !== 2'b10 || rd_last[3] !== 1'b1) begin fails++; $display("FAIL oob_beat3 got %h/%b/%b want 00000000/10/1", rd_data[3], rd_resp[3], rd_last[3]); end
        // Burst straddling the end: first beat lands, second is an error beat
        wr_data[0] = 32'h1515_1515; wr_data[1] = 32'h1616_1616;
        write_burst(32'h3C, 2, 4'hF, 1'b0, br, to);
        tests++; if (br !== 2'b10) begin fails++; $display("FAIL oob_wr_bresp got %b want 10", br); end
        read_burst(32'h3C, 1, lat, to);
        tests++; if (rd_data[0] !== 32'h1515_1515) begin fails++; $display("FAIL oob_wr_word15 got %h want 15151515", rd_data[0]); end
        // Missing wlast flags an error but the beat still lands
        wr_data[0] = 32'hBADC_0DE0;
        write_burst(32'h34, 1, 4'hF, 1'b1, br, to);
        tests++; if (br !== 2'b10) begin fails++; $display("FAIL wlast_bresp got %b want 10", br); end
        read_burst(32'h34, 1, lat, to);
        tests++; if (rd_data[0] !== 32'hBADC_0DE0) begin fails++; $display("FAIL wlast_data got %h want badc0de0", rd_data[0]); end
        tests++; if (to) begin fails++; $display("FAIL oob_timeout got timeout want none"); end
    endtask

    task automatic test_backpressure();
        int c;
        axi_araddr = 32'h10; axi_arlen = 8'd3; axi_arvalid = 1'b1; axi_rready = 1'b0; #1;
        c = 0;
        while (!axi_arready && c < 50) begin @(posedge clk); #2; c++; end
        @(posedge clk); #1; axi_arvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            axi_rready = (i != 1); #1;
            c = 0;
            while (!axi_rvalid && c < 50) begin @(posedge clk); #2; c++; end
            tests++; if (c >= 50) begin fails++; $display("FAIL bp_timeout[%0d] got timeout want rvalid", i); end
            if (i == 1) begin
                for (int k = 0; k < 5; k++) begin
                    @(posedge clk); #2;
                    tests++;
                    if (axi_rvalid !== 1'b1 || axi_rdata !== 32'hA1 || axi_rlast !== 1'b0) begin
                        fails++; $display("FAIL bp_hold[%0d] got v=%b d=%h l=%b want v=1 d=000000a1 l=0", k, axi_rvalid, axi_rdata, axi_rlast);
                    end
                end
                axi_rready = 1'b1;
            end
            tests++; if (axi_rdata !== 32'hA0 + 32'(i)) begin fails++; $display("FAIL bp_rdata[%0d] got %h want %h", i, axi_rdata, 32'hA0 + 32'(i)); end
            tests++; if (axi_rlast !== (i == 3)) begin fails++; $display("FAIL bp_rlast[%0d] got %b want %b", i, axi_rlast, (i == 3)); end
            @(posedge clk); #1;
        end
        axi_rready = 1'b0; #1;
        tests++; if (axi_rvalid !== 1'b0) begin fails++; $display("FAIL bp_extra_beat got rvalid=%b want 0", axi_rvalid); end
        tick();
    endtask

    task automatic test_loader();
        int c; int lat; bit to; logic [1:0] br;
        axi_awaddr = 32'h20; axi_awlen = 8'd3; axi_awvalid = 1'b1; #1;
        c = 0;
        while (!axi_awready && c < 50) begin @(posedge clk); #2; c++; end
        @(posedge clk); #1; axi_awvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            axi_wdata = 32'h8000_0080 + 32'(i); axi_wstrb = 4'hF; axi_wlast = (i == 3); axi_wvalid = 1'b1;
            if (i == 2) begin
                loader_we = 1'b1; loader_addr = 32'h30; loader_data = 32'hC0DE_C0DE; #1;
                tests++; if (axi_wready !== 1'b0) begin fails++; $display("FAIL loader_wready got %b want 0", axi_wready); end
                @(posedge clk); #1; loader_we = 1'b0;
            end
            #1;
            c = 0;
            while (!axi_wready && c < 50) begin @(posedge clk); #2; c++; end
            tests++; if (c >= 50) begin fails++; $display("FAIL loader_beat_timeout[%0d] got timeout want wready", i); end
            @(posedge clk); #1;
        end
        axi_wvalid = 1'b0; axi_wlast = 1'b0; axi_bready = 1'b1; #1;
        c = 0;
        while (!axi_bvalid && c < 50) begin @(posedge clk); #2; c++; end
        br = axi_bresp;
        @(posedge clk); #1; axi_bready = 1'b0;
        tests++; if (br !== 2'b00) begin fails++; $display("FAIL loader_bresp got %b want 00", br); end
        read_burst(32'h20, 5, lat, to);
        for (int i = 0; i < 4; i++) begin
            tests++; if (rd_data[i] !== 32'h8000_0080 + 32'(i)) begin fails++; $display("FAIL loader_axi_word[%0d] got %h want %h", i, rd_data[i], 32'h8000_0080 + 32'(i)); end
        end
        tests++; if (rd_data[4] !== 32'hC0DE_C0DE) begin fails++; $display("FAIL loader_word got %h want c0dec0de", rd_data[4]); end
    endtask

    task automatic test_reset_mid();
        int c; int lat; bit to;
        // Preload words 0..3 through the loader while reset is held
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            loader_we = 1'b1; loader_addr = 32'(i * 4); loader_data = 32'h0000_1110 + 32'(i);
            tick();
        end
        loader_we = 1'b0; reset = 1'b0;
        tick();
        axi_awaddr = 32'h0; axi_awlen = 8'd3; axi_awvalid = 1'b1; #1;
        c = 0;
        while (!axi_awready && c < 50) begin @(posedge clk); #2; c++; end
        @(posedge clk); #1; axi_awvalid = 1'b0;
        axi_wdata = 32'hAAAA_0000; axi_wstrb = 4'hF; axi_wlast = 1'b0; axi_wvalid = 1'b1; #1;
        c = 0;
        while (!axi_wready && c < 50) begin @(posedge clk); #2; c++; end
        @(posedge clk); #1;
        axi_wdata = 32'hBBBB_1111; reset = 1'b1; #1;
        tests++; if (axi_wready !== 1'b0) begin fails++; $display("FAIL rstmid_wready got %b want 0", axi_wready); end
        @(posedge clk); #1;
        reset = 1'b0; axi_wvalid = 1'b0; #1;
        tests++; if (axi_awready !== 1'b1) begin fails++; $display("FAIL rstmid_awready got %b want 1", axi_awready); end
        tests++; if (axi_wready !== 1'b0) begin fails++; $display("FAIL rstmid_idle_wready got %b want 0", axi_wready); end
        @(posedge clk); #1;
        read_burst(32'h0, 4, lat, to);
        tests++; if (to) begin fails++; $display("FAIL rstmid_timeout got timeout want none"); end
        tests++; if (rd_data[0] !== 32'hAAAA_0000) begin fails++; $display("FAIL rstmid_word0 got %h want aaaa0000", rd_data[0]); end
        for (int i = 1; i < 4; i++) begin
            tests++; if (rd_data[i] !== 32'h0000_1110 + 32'(i)) begin fails++; $display("FAIL rstmid_word[%0d] got %h want %h", i, rd_data[i], 32'h0000_1110 + 32'(i)); end
        end
    endtask

    initial begin
        tests = 0; fails = 0;
        reset = 1'b1;
        axi_awaddr = '0; axi_awlen = '0; axi_awvalid = 1'b0;
        axi_wdata = '0; axi_wstrb = '0; axi_wlast = 1'b0; axi_wvalid = 1'b0;
        axi_bready = 1'b0;
        axi_araddr = '0; axi_arlen = '0; axi_arvalid = 1'b0;
        axi_rready = 1'b0;
        loader_we = 1'b0; loader_addr = '0; loader_data = '0;
        for (int i = 0; i < 8; i++) wr_data[i] = '0;
        tick();
        test_reset();
        test_burst();
        test_strobe();
        test_oob();
        test_backpressure();
        test_loader();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no finish want finish before 500us");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axi_sram.md
AXI_SRAM -- requirements
Module: axi_sram

Parameters
REQ-001 The module SHALL have parameter MEM_SIZE, default 'h40000, meaning the number of DATA_WIDTH-bit words in the array.
REQ-002 The module SHALL have parameter DATA_WIDTH, default 32, meaning the data bus width in bits (legal values 32, 64, 128, 256, 512).
REQ-003 The module SHALL derive localparam BYTE_LANES = DATA_WIDTH/8 and WORD_SHIFT = $clog2(BYTE_LANES).

Interface
REQ-004 clk  in  1  single clock; every flop is on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 axi_awaddr/axi_awlen/axi_awvalid  in  32/8/1; axi_awready  out  1: write address channel.
REQ-007 axi_wdata/axi_wstrb/axi_wlast/axi_wvalid  in  DATA_WIDTH/BYTE_LANES/1/1; axi_wready  out  1: write data channel.
REQ-008 axi_bresp/axi_bvalid  out  2/1; axi_bready  in  1: write response channel.
REQ-009 axi_araddr/axi_arlen/axi_arvalid  in  32/8/1; axi_arready  out  1: read address channel.
REQ-010 axi_rdata/axi_rresp/axi_rlast/axi_rvalid  out  DATA_WIDTH/2/1/1; axi_rready  in  1: read data channel.
REQ-011 loader_we  in  1; loader_addr  in  32; loader_data  in  DATA_WIDTH: loader writes a full word at byte address loader_addr and is honoured even while reset is high.

Function
REQ-012 The state machine SHALL have exactly the states IDLE, READ_ADDR, READ_BURST, WRITE_BURST and WRITE_RESP.
REQ-013 In IDLE, awready and arready SHALL both be 1; in every other state, and while reset is high, both SHALL be 0.
REQ-014 In IDLE with awvalid=1, the block SHALL latch awaddr>>WORD_SHIFT into the burst address and awlen into the beat count, clear the error flag, and go to WRITE_BURST; awvalid SHALL take priority over arvalid.
REQ-015 In IDLE with only arvalid=1, the block SHALL latch araddr and arlen in the same way and go to READ_ADDR.
REQ-016 A read SHALL have a 2-cycle latency from the AR handshake to first rvalid: READ_ADDR issues the SRAM read and then enters READ_BURST.
REQ-017 In READ_BURST, rvalid SHALL be 1 and rlast SHALL be 1 exactly when the beat count is 0.
REQ-018 rdata, rresp and rlast SHALL be held stable while rvalid=1 and rready=0.
REQ-019 A read beat accepted (rvalid && rready) with count 0 SHALL return the block to IDLE; with count nonzero it SHALL increment the address, decrement the count and return to READ_ADDR.
REQ-020 In WRITE_BURST, wready SHALL be 1 except in a cycle where loader_we=1, in which case wready SHALL be 0 and the loader write SHALL take the SRAM write port.
REQ-021 Each accepted write beat SHALL update only the byte lanes whose wstrb bit is 1; wstrb=0 SHALL leave the word unchanged.
REQ-022 An accepted write beat with count 0 SHALL go to WRITE_RESP; otherwise it SHALL increment the address and decrement the count.
REQ-023 In WRITE_RESP, bvalid SHALL be 1; bvalid && bready SHALL return the block to IDLE.
REQ-024 Any beat whose word address is >= MEM_SIZE SHALL leave memory unmodified and set the error flag; a read beat at such an address SHALL return rdata=0 with rresp=2'b10 for that beat only.
REQ-025 The burst address SHALL NOT wrap; it is a full-width increment, so every beat beyond MEM_SIZE is an error beat.
REQ-026 A write beat with wlast mismatching (count==0) SHALL set the error flag while the beat is still written.
REQ-027 bresp SHALL be 2'b10 if the error flag is set, otherwise 2'b00; a read with no error SHALL drive rresp 2'b00.
REQ-028 The loader write word address SHALL be loader_addr>>WORD_SHIFT; a loader write with address >= MEM_SIZE SHALL be dropped silently.

Reset
REQ-029 While reset is high, the state SHALL be IDLE and the burst address, count and error flag SHALL be 0.
REQ-030 While reset is high, rvalid, bvalid, wready, awready and arready SHALL be 0; rresp and bresp SHALL be 2'b00 and rlast SHALL be 0.
REQ-031 Reset asserted mid-burst SHALL abandon the burst on the next edge with no further SRAM writes; words already written SHALL persist.

Verification
REQ-032 DATA_WIDTH=32: write awaddr=0x10, awlen=3, data 0xA0..0xA3, then read the same -> bresp 00; rdata A0,A1,A2,A3; rlast only on beat 4; first rvalid 2 cycles after the AR handshake.
REQ-033 Write 0xFFFFFFFF to word 0, then write 0x11223344 with wstrb=4'b0101, then read -> 0xFF22FF44.
REQ-034 MEM_SIZE=16: read araddr=0x38, arlen=3 -> beats 0 and 1 rresp 00 with stored data; beats 2 and 3 rdata 0, rresp 10.
REQ-035 Hold rready=0 for 5 cycles mid-burst -> rdata, rlast and rvalid stay constant; no beat is skipped or repeated.
REQ-036 Assert loader_we during beat 2 of a 4-beat write -> wready=0 that cycle; the loader word and all 4 AXI beats land at their addresses; bresp 00.
REQ-037 Assert reset during beat 1 of a 4-beat write -> only beat 0 is written; awready=1 on the first cycle after reset deasserts.
